// File: rtl/param_updn_counter.sv
// param_updn_counter: modulo-MODULO up/down counter with wrap or saturate at
// the terminal count, a synchronous parallel load, and a one-cycle event pulse
// for each step taken at the terminal count.
// Optional feature: define COUNTER_PRESCALE_EN to compile in a prescaler that
// advances the count once every PRESCALE enabled clocks. The 'test' input
// bypasses the prescaler. Without the macro, every enabled clock is a step and
// 'test' is ignored.
module param_updn_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULO   = 10,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ud,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             test,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             evt
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULO - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             evt_q, evt_d;
    logic             tick;
    logic             step;

`ifdef COUNTER_PRESCALE_EN
    localparam int          PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q, pre_d;

    // Prescaler: counts enabled cycles; restarts on load or on each tick.
    always_comb begin
        tick  = test || (pre_q == PRE_MAX);
        pre_d = pre_q;
        if (load) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
        end
    end

    // Prescaler register; reset discards any partial count.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    // 'test' only matters for the prescaler, which is not built here.
    logic unused_test;
    assign unused_test = test;

    // Without a prescaler every enabled clock is a step.
    always_comb begin
        tick = 1'b1;
    end
`endif

    assign step = en && tick;
    assign tc   = ud ? (cnt_q == CNT_MAX) : (cnt_q == '0);
    assign cnt  = cnt_q;
    assign evt  = evt_q;

    // Next count: load beats step beats hold; terminal count wraps or saturates.
    always_comb begin
        cnt_d = cnt_q;
        evt_d = 1'b0;
        if (load) begin
            cnt_d = ({1'b0, din} < MOD_EXT) ? din : CNT_MAX;
        end else if (step) begin
            if (!tc) begin
                cnt_d = ud ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
            end else begin
                evt_d = 1'b1;
                if (!sat) begin
                    cnt_d = ud ? '0 : CNT_MAX;
                end
            end
        end
    end

    // Count and event registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            evt_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            evt_q <= evt_d;
        end
    end

endmodule

// File: tb/tb_param_updn_counter.sv
// Testbench for param_updn_counter (WIDTH=4, MODULO=10, PRESCALE=4).
// Works with or without COUNTER_PRESCALE_EN; the reference model follows the
// same macro.
module tb_param_updn_counter;

  localparam int W = 4;
  localparam int M = 10;
  localparam int P = 4;

  // ---------------- clock / reset block ----------------
  logic         clk = 1'b0;
  logic         rst, en, ud, sat, load, test;
  logic [W-1:0] din;
  logic [W-1:0] cnt;
  logic         tc, evt;

  always #5 clk = ~clk;

  param_updn_counter #(.WIDTH(W), .MODULO(M), .PRESCALE(P)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .ud   (ud),
    .sat  (sat),
    .load (load),
    .din  (din),
    .test (test),
    .cnt  (cnt),
    .tc   (tc),
    .evt  (evt)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  // Reference state: integer count, number of enabled cycles since the
  // prescaler last restarted, and the pending event flag.
  int  m_cnt    = 0;
  int  m_pre    = 0;
  int  m_evt    = 0;
  bit  tc_valid = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural rules for one rising edge, using the inputs now applied.
  task automatic model_edge();
    bit tick_m;
    bit at_end;
    if (rst) begin
      m_cnt = 0; m_pre = 0; m_evt = 0;
    end else if (load) begin
      m_cnt = (int'(din) < M) ? int'(din) : M - 1;
      m_pre = 0; m_evt = 0;
    end else if (en) begin
`ifdef COUNTER_PRESCALE_EN
      if (test || (m_pre + 1 == P)) begin
        tick_m = 1'b1; m_pre = 0;
      end else begin
        tick_m = 1'b0; m_pre = m_pre + 1;
      end
`else
      tick_m = 1'b1;
`endif
      if (tick_m) begin
        at_end = ud ? (m_cnt == M - 1) : (m_cnt == 0);
        m_evt  = at_end ? 1 : 0;
        if (!at_end)  m_cnt = ud ? m_cnt + 1 : m_cnt - 1;
        else if (!sat) m_cnt = ud ? 0 : M - 1;
      end else begin
        m_evt = 0;
      end
    end else begin
      m_evt = 0;
    end
    exp_q.push_back(W'(m_cnt));
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input bit r, input bit e, input bit u, input bit s,
                     input bit l, input bit t, input logic [W-1:0] d);
    logic [W-1:0] exp_cnt;
    rst = r; en = e; ud = u; sat = s; load = l; test = t; din = d;
    #1;
    if (tc_valid)
      check_val("tc", tc, (ud ? (m_cnt == M - 1) : (m_cnt == 0)) ? 1 : 0);
    model_edge();
    @(posedge clk);
    #1;
    exp_cnt = exp_q.pop_front();
    check_val("cnt", cnt, exp_cnt);
    check_val("evt", evt, m_evt);
    tc_valid = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; en = 1'b0; ud = 1'b0; sat = 1'b0; load = 1'b0; test = 1'b0; din = '0;
    #2;

    // Reset, then explicit reset values.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);
    check_val("rst_cnt", cnt, 0);
    check_val("rst_evt", evt, 0);
    ud = 1'b0; #1;
    check_val("rst_tc_down", tc, 1);

    // Count up with wrap for 40 cycles.
    for (int i = 0; i < 40; i++) cyc(0, 1, 1, 0, 0, 0, 0);

    // Load 2, count down saturating with prescaler bypass.
    cyc(0, 0, 0, 1, 1, 0, 4'd2);
    check_val("load2", cnt, 2);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, 0, 1, 0);
    check_val("sat_low_cnt", cnt, 0);
    check_val("sat_low_tc", tc, 1);

    // Out-of-range load clamps; load beats a concurrent step.
    cyc(0, 0, 1, 0, 1, 0, 4'd13);
    check_val("load13_clamp", cnt, 9);
    check_val("load13_tc_up", tc, 1);
    cyc(0, 1, 1, 0, 1, 1, 4'd5);
    check_val("load_wins", cnt, 5);

    // Enable gaps: 3 enabled, 10 idle, 1 enabled.
    cyc(0, 0, 1, 0, 1, 0, 4'd0);
    for (int i = 0; i < 3; i++)  cyc(0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0);
`ifdef COUNTER_PRESCALE_EN
    check_val("gap_one_step", cnt, 1);
`else
    check_val("gap_one_step", cnt, 4);
`endif

    // Reset overrides load and enable; partial prescale discarded.
    cyc(0, 1, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 1, 0, 4'd7);
    check_val("rst_over_load", cnt, 0);
    check_val("rst_over_evt", evt, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 1, 0, 0, 0, 0);

    // Up-count with test toggling.
    for (int i = 0; i < 12; i++) cyc(0, 1, 1, 0, 0, i[0], 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 49) == 0),
          ($urandom_range(0, 3) != 0),
          $urandom_range(0, 1),
          $urandom_range(0, 1),
          ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 4) == 0),
          W'($urandom_range(0, 15)));
    end

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_updn_counter.md
PARAM_UPDN_COUNTER -- requirements
Module: param_updn_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits (legal range 2..16).
REQ-002 SHALL have parameter MODULO, default 10, count range 0..MODULO-1 (legal range 2..2^WIDTH).
REQ-003 SHALL have parameter PRESCALE, default 4, enabled clocks per count step (legal range 1..256).
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have port en, input, 1, count enable; prescaler and counter advance only when high.
REQ-007 SHALL have port ud, input, 1, direction: 1 = up, 0 = down.
REQ-008 SHALL have port sat, input, 1, boundary mode: 1 = saturate, 0 = wrap.
REQ-009 SHALL have port load, input, 1, synchronous parallel load strobe.
REQ-010 SHALL have port din, input, WIDTH, load value.
REQ-011 SHALL have port test, input, 1, prescaler bypass (active only with the Configuration macro).
REQ-012 SHALL have port cnt, output, WIDTH, registered count value.
REQ-013 SHALL have port tc, output, 1, terminal count: combinational, high when (ud=1 and cnt=MODULO-1) or (ud=0 and cnt=0).
REQ-014 SHALL have port evt, output, 1, registered one-cycle pulse marking a step attempted at the terminal count.

Function
REQ-015 SHALL apply update priority per edge: rst > load > step > hold.
REQ-016 SHALL, on load=1, set cnt to din when din<MODULO, otherwise to MODULO-1; clear prescaler; evt=0.
REQ-017 SHALL define step = en AND tick; tick defined in Configuration; cnt changes on that edge, visible the following cycle (latency 1).
REQ-018 SHALL, on step with ud=1 and cnt<MODULO-1, set cnt to cnt+1; with ud=0 and cnt>0, set cnt to cnt-1.
REQ-019 SHALL, on step at terminal count with sat=0, wrap: up MODULO-1 -> 0, down 0 -> MODULO-1.
REQ-020 SHALL, on step at terminal count with sat=1, hold cnt unchanged.
REQ-021 SHALL assert evt for exactly the cycle after any step taken at terminal count (wrap or saturate), else 0.
REQ-022 SHALL sample ud and sat on the stepping edge only; changes between steps have no side effect on cnt or prescaler.
REQ-023 SHALL hold cnt and the prescaler state whenever en=0 and load=0.
REQ-024 SHALL never present cnt >= MODULO.

Reset
REQ-025 SHALL, on rst=1 at a clk edge, set cnt=0, evt=0, prescaler=0, overriding load and en.
REQ-026 SHALL let tc follow cnt/ud combinationally during reset (tc=1 if ud=0, since cnt=0).
REQ-027 SHALL resume normal operation on the first edge after rst deasserts; a reset mid-prescale discards the partial count.

Configuration
REQ-028 SHALL use macro COUNTER_PRESCALE_EN to compile in the prescaler.
REQ-029 SHALL, with COUNTER_PRESCALE_EN defined, count en=1 cycles in a 0..PRESCALE-1 prescaler; tick=1 when it equals PRESCALE-1 (then it returns to 0) or when test=1 (prescaler then cleared).
REQ-030 SHALL, without COUNTER_PRESCALE_EN, contain no prescaler logic; tick=1 constantly; test is ignored and left unused.

Verification (WIDTH=4, MODULO=10, PRESCALE=4, macro defined unless noted)
REQ-031 SHALL cover: rst, then en=1 ud=1 sat=0 test=0 for 40 cycles -> cnt 0..9 stepping every 4th cycle, wraps 9->0, evt one cycle after the wrap edge.
REQ-032 SHALL cover: load din=2, then en=1 ud=0 sat=1 test=1 -> cnt 2,1,0,0,0 one per cycle; evt pulses on each held-at-0 step; tc=1 once cnt=0.
REQ-033 SHALL cover: load din=13 -> cnt=9 next cycle; tc=1 with ud=1; load din=5 together with en=1 test=1 -> cnt=5 (load wins).
REQ-034 SHALL cover: en=1 for 3 cycles, en=0 for 10 cycles, en=1 for 1 cycle -> exactly one step after the 4th enabled cycle.
REQ-035 SHALL cover: rst asserted with load=1 din=7 en=1 -> cnt=0, evt=0; prescaler restarts from 0 after release.
REQ-036 SHALL cover: macro undefined, en=1 ud=1 sat=0, test toggling -> cnt steps every cycle 0..9,0; test has no effect.
